// File: rtl/arb_requester.sv
// Requester-side master for a 2-port round-robin arbiter.
// Accepts a burst command, requests the bus, streams beats while granted, then releases.
module arb_requester #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 15,
  localparam int LEN_W    = $clog2(MAX_BURST + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_req,
  input  logic              i_gnt,
  output logic              o_bus_valid,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_done,
  output logic              o_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic [1:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [DATA_W-1:0] base_q;
  logic [WAIT_W-1:0] wait_q;
  logic [LEN_W-1:0]  len_c;

  always_comb begin
    len_c = i_cmd_len;
    if (i_cmd_len > LEN_W'(MAX_BURST)) len_c = LEN_W'(MAX_BURST);
  end

  assign o_cmd_ready = (state == S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      base_q      <= '0;
      wait_q      <= '0;
      o_req       <= 1'b0;
      o_bus_valid <= 1'b0;
      o_bus_data  <= '0;
      o_done      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_timeout   <= 1'b0;
      o_bus_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            len_q  <= len_c;
            base_q <= i_cmd_data;
            beat_q <= '0;
            wait_q <= '0;
            if (len_c == '0) begin
              state  <= S_REL;
              o_done <= 1'b1;
            end else begin
              state <= S_REQ;
              o_req <= 1'b1;
            end
          end
        end
        // REQ shares XFER's logic: beat_q is 0 and len_q is non-zero there,
        // so the completion branch can only fire from XFER.
        S_REQ, S_XFER: begin
          if (beat_q == len_q) begin
            state  <= S_REL;
            o_req  <= 1'b0;
            o_done <= 1'b1;
          end else if (i_gnt) begin
            state       <= S_XFER;
            o_bus_valid <= 1'b1;
            o_bus_data  <= base_q + DATA_W'(beat_q);
            beat_q      <= beat_q + LEN_W'(1);
            wait_q      <= '0;
          end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            state     <= S_IDLE;
            o_req     <= 1'b0;
            o_timeout <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: single instance with driven grant, then two
// instances behind a small round-robin arbiter model; beats checked via scoreboard queues.
module tb_arb_requester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cv0, cv1;
  logic [2:0] l0, l1;
  logic [7:0] d0, d1;
  logic       tg;
  logic       arb_mode;
  logic       rdy0, rdy1, req0, req1, gnt0, gnt1;
  logic       v0, v1, dn0, dn1, to0, to1;
  logic [7:0] bd0, bd1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int overlap = 0;
  int done0_cyc = -1;
  int first_v1 = -1;
  int n;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  logic ag0, ag1, ptr, nptr, pick0, pick1;

  always #5 clk = ~clk;

  assign gnt0 = arb_mode ? ag0 : tg;
  assign gnt1 = arb_mode ? ag1 : 1'b0;

  arb_requester #(.DATA_W(8), .MAX_BURST(4), .TIMEOUT(15)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cv0), .o_cmd_ready(rdy0),
    .i_cmd_len(l0), .i_cmd_data(d0), .o_req(req0), .i_gnt(gnt0),
    .o_bus_valid(v0), .o_bus_data(bd0), .o_done(dn0), .o_timeout(to0)
  );

  arb_requester #(.DATA_W(8), .MAX_BURST(4), .TIMEOUT(15)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cv1), .o_cmd_ready(rdy1),
    .i_cmd_len(l1), .i_cmd_data(d1), .o_req(req1), .i_gnt(gnt1),
    .o_bus_valid(v1), .o_bus_data(bd1), .o_done(dn1), .o_timeout(to1)
  );

  // Arbiter model: holds grant while owner requests; rotates priority on release.
  always_comb begin
    nptr = ptr;
    if (ag0 && !req0) nptr = 1'b1;
    else if (ag1 && !req1) nptr = 1'b0;
    pick0 = req0 && (!req1 || !nptr);
    pick1 = req1 && !pick0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !arb_mode) begin
      ag0 <= 1'b0; ag1 <= 1'b0; ptr <= 1'b0;
    end else if (!((ag0 && req0) || (ag1 && req1))) begin
      ag0 <= pick0; ag1 <= pick1; ptr <= nptr;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (v0 && v1) overlap++;
      if (v0) begin
        if (q0.size() == 0) chk("beat0_unexpected", {24'd0, bd0}, 32'hFFFF_FFFF);
        else chk("beat0_data", {24'd0, bd0}, {24'd0, q0.pop_front()});
      end
      if (v1) begin
        if (q1.size() == 0) chk("beat1_unexpected", {24'd0, bd1}, 32'hFFFF_FFFF);
        else chk("beat1_data", {24'd0, bd1}, {24'd0, q1.pop_front()});
      end
      if (arb_mode && dn0) done0_cyc = cyc;
      if (arb_mode && v1 && first_v1 < 0) first_v1 = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd0(input logic [2:0] len, input logic [7:0] data);
    cv0 = 1'b1; l0 = len; d0 = data;
    tick();
    cv0 = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return dn0;
      1:       return to0;
      default: return dn1;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int sel, input int limit);
    int k;
    k = 0;
    while (!sig(sel) && k < limit) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, sig(sel)}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cv0 = 1'b0; cv1 = 1'b0; l0 = '0; l1 = '0; d0 = '0; d1 = '0;
    tg = 1'b0; arb_mode = 1'b0;
    #2;
    chk("rst_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_req",   {31'd0, req0}, 32'd0);
    chk("rst_valid", {31'd0, v0},   32'd0);
    chk("rst_done",  {31'd0, dn0},  32'd0);
    chk("rst_to",    {31'd0, to0},  32'd0);
    chk("rst_data",  {24'd0, bd0},  32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Simple burst, grant one cycle after request
    q0.push_back(8'h10); q0.push_back(8'h11); q0.push_back(8'h12);
    cmd0(3'd3, 8'h10);
    chk("t2_req",   {31'd0, req0}, 32'd1);
    chk("t2_ready", {31'd0, rdy0}, 32'd0);
    tick();
    tg = 1'b1;
    wait_sig("t2_done", 0, 20);
    chk("t2_rel_req",   {31'd0, req0}, 32'd0);
    chk("t2_rel_valid", {31'd0, v0},   32'd0);
    chk("t2_rel_to",    {31'd0, to0},  32'd0);
    tick();
    chk("t2_done_pulse", {31'd0, dn0}, 32'd0);
    chk("t2_ready_back", {31'd0, rdy0}, 32'd1);
    chk("t2_q_empty", q0.size(), 32'd0);

    // Wrap and clamp: len 7 clamps to 4 beats
    q0.push_back(8'hFE); q0.push_back(8'hFF); q0.push_back(8'h00); q0.push_back(8'h01);
    cmd0(3'd7, 8'hFE);
    wait_sig("t3_done", 0, 20);
    tick();
    chk("t3_q_empty", q0.size(), 32'd0);

    // Timeout with grant held low
    tg = 1'b0;
    cmd0(3'd2, 8'h20);
    n = 0;
    while (req0 && n < 40) begin
      n++;
      tick();
    end
    chk("t4_req_cycles", n, 32'd15);
    chk("t4_timeout", {31'd0, to0}, 32'd1);
    chk("t4_no_done", {31'd0, dn0}, 32'd0);
    tick();
    chk("t4_to_pulse", {31'd0, to0}, 32'd0);
    chk("t4_ready",    {31'd0, rdy0}, 32'd1);

    // Revoked grant mid-burst
    q0.push_back(8'h40); q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h43);
    cmd0(3'd4, 8'h40);
    tg = 1'b1;
    tick(); chk("t5_b0", {31'd0, v0}, 32'd1);
    tick(); chk("t5_b1", {31'd0, v0}, 32'd1);
    tg = 1'b0;
    tick(); chk("t5_stall0", {31'd0, v0}, 32'd0);
    tick(); chk("t5_stall1", {31'd0, v0}, 32'd0);
    tg = 1'b1;
    tick(); chk("t5_b2", {31'd0, v0}, 32'd1);
    tick(); chk("t5_b3", {31'd0, v0}, 32'd1);
    tick(); chk("t5_done", {31'd0, dn0}, 32'd1);
    chk("t5_q_empty", q0.size(), 32'd0);
    tick();

    // Asynchronous reset mid-transfer
    q0.push_back(8'h50); q0.push_back(8'h51); q0.push_back(8'h52); q0.push_back(8'h53);
    cmd0(3'd4, 8'h50);
    tick(); tick();
    chk("t1_in_xfer", {31'd0, v0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_req",   {31'd0, req0}, 32'd0);
    chk("t1_valid", {31'd0, v0},   32'd0);
    chk("t1_ready", {31'd0, rdy0}, 32'd1);
    chk("t1_data",  {24'd0, bd0},  32'd0);
    q0.delete();
    tick();
    rst_n = 1'b1;
    tg = 1'b0;
    tick();

    // Two requesters behind the arbiter
    arb_mode = 1'b1;
    tick();
    q0.push_back(8'h80); q0.push_back(8'h81);
    q1.push_back(8'h90); q1.push_back(8'h91);
    cv0 = 1'b1; l0 = 3'd2; d0 = 8'h80;
    cv1 = 1'b1; l1 = 3'd2; d1 = 8'h90;
    tick();
    cv0 = 1'b0; cv1 = 1'b0;
    chk("t6_both_req", {30'd0, req0, req1}, 32'd3);
    wait_sig("t6_done0", 0, 30);
    wait_sig("t6_done1", 2, 30);
    chk("t6_overlap", overlap, 32'd0);
    chk("t6_second_after_release", first_v1, done0_cyc + 2);
    chk("t6_q0_empty", q0.size(), 32'd0);
    chk("t6_q1_empty", q1.size(), 32'd0);
    chk("t6_no_timeout", {30'd0, to0, to1}, 32'd0);
    tick();
    chk("t6_ready1", {31'd0, rdy1}, 32'd1);

    // Zero-length command completes without requesting
    cmd0(3'd0, 8'h00);
    chk("t6_len0_done", {31'd0, dn0}, 32'd1);
    chk("t6_len0_req",  {31'd0, req0}, 32'd0);
    tick();
    chk("t6_len0_pulse", {31'd0, dn0}, 32'd0);
    chk("t6_len0_ready", {31'd0, rdy0}, 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
